// File: rtl/exe_mem_req_if.sv
// exe_mem_req_if: SRAM-like data request channel (address phase plus data_ok return).
interface exe_mem_req_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok
  );
endinterface

// File: rtl/exe_mem_req.sv
// exe_mem_req: EXE-stage memory request issue, strobe/store-data generation, orphan tracking.
// Optional macro ES_ALE_CHECK_EN: misaligned accesses raise es_ale and issue no request.
module exe_mem_req #(
  parameter int unsigned PAYLOAD_W = 150,
  parameter int unsigned ORPHAN_W  = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ds2es_valid,
  output logic                 es_allowin,
  input  logic                 ds_mem_en,
  input  logic                 ds_mem_we,
  input  logic [1:0]           ds_mem_size,
  input  logic [31:0]          ds_mem_addr,
  input  logic [31:0]          ds_store_data,
  input  logic [PAYLOAD_W-1:0] ds_payload,
  input  logic                 ms_allowin,
  output logic                 es2ms_valid,
  output logic [PAYLOAD_W-1:0] es2ms_payload,
  output logic                 es_wait_data_ok,
  output logic [1:0]           es_addr_lo,
  output logic                 es_ale,
  output logic                 es_drop_data_ok,
  exe_mem_req_if.master        data_sram,
  input  logic                 ms_ex,
  input  logic                 wb_ex
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, CANCEL} state_t;

  state_t                 state;
  logic                   req_hold;
  logic [ORPHAN_W-1:0]    orphan_cnt;
  logic                   we_q;
  logic [1:0]             size_q;
  logic [31:0]            addr_q;
  logic [3:0]             wstrb_q;
  logic [31:0]            wdata_q;
  logic [PAYLOAD_W-1:0]   payload_q;
  logic                   ale_q;
  logic                   wait_q;

  logic                   ale_c;
  logic [3:0]             wstrb_c;
  logic [31:0]            wdata_c;
  logic                   cnt_max_c;
  logic                   req_c;
  logic                   load_c;
  logic                   inc_c;
  logic                   dec_c;
  state_t                 load_state_c;

`ifdef ES_ALE_CHECK_EN
  assign ale_c = ds_mem_en & (((ds_mem_size == 2'd1) & ds_mem_addr[0]) |
                              (ds_mem_size[1] & (|ds_mem_addr[1:0])));
`else
  assign ale_c = 1'b0;
`endif

  // Store strobes and lane-replicated data; size 3 behaves as word.
  always_comb begin
    wstrb_c = 4'b1111;
    wdata_c = ds_store_data;
    case (ds_mem_size)
      2'd0: begin
        wstrb_c = 4'b0001 << ds_mem_addr[1:0];
        wdata_c = {4{ds_store_data[7:0]}};
      end
      2'd1: begin
        wstrb_c = ds_mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{ds_store_data[15:0]}};
      end
      default: ;
    endcase
    if (!ds_mem_we) wstrb_c = 4'b0000;
  end

  assign cnt_max_c    = &orphan_cnt;
  assign es_allowin   = ((state == IDLE) | ((state == DONE) & ms_allowin)) & ~cnt_max_c;
  assign load_c       = ds2es_valid & es_allowin & ~wb_ex;
  assign load_state_c = (ds_mem_en & ~ale_c) ? REQ : DONE;

  // Once raised, the request is held until addr_ok regardless of ms_ex/wb_ex.
  assign req_c = ((state == REQ) & (req_hold | (~ms_ex & ~wb_ex))) | (state == CANCEL);

  // An accepted request whose instruction is flushed leaves a data_ok to discard.
  assign inc_c = ((state == REQ) & wb_ex & req_c & data_sram.addr_ok) |
                 ((state == DONE) & wb_ex & wait_q) |
                 ((state == CANCEL) & data_sram.addr_ok);
  assign dec_c = data_sram.data_ok & (orphan_cnt != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      req_hold   <= 1'b0;
      orphan_cnt <= '0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= 32'd0;
      wstrb_q    <= 4'd0;
      wdata_q    <= 32'd0;
      payload_q  <= '0;
      ale_q      <= 1'b0;
      wait_q     <= 1'b0;
    end else begin
      if (load_c) begin
        we_q      <= ds_mem_we;
        size_q    <= ds_mem_size;
        addr_q    <= ds_mem_addr;
        wstrb_q   <= wstrb_c;
        wdata_q   <= wdata_c;
        payload_q <= ds_payload;
        ale_q     <= ale_c;
      end

      if (inc_c & ~dec_c & ~cnt_max_c) orphan_cnt <= orphan_cnt + ORPHAN_W'(1);
      else if (dec_c & ~inc_c)         orphan_cnt <= orphan_cnt - ORPHAN_W'(1);

      case (state)
        IDLE: if (load_c) state <= load_state_c;
        REQ: begin
          if (wb_ex) begin
            if (req_hold & ~data_sram.addr_ok) begin
              state <= CANCEL;
            end else begin
              state    <= IDLE;
              req_hold <= 1'b0;
            end
          end else if (req_c & data_sram.addr_ok) begin
            state    <= DONE;
            wait_q   <= 1'b1;
            req_hold <= 1'b0;
          end else if (req_c) begin
            req_hold <= 1'b1;
          end
        end
        DONE: begin
          if (wb_ex) begin
            state  <= IDLE;
            wait_q <= 1'b0;
          end else if (ms_allowin) begin
            wait_q <= 1'b0;
            state  <= load_c ? load_state_c : IDLE;
          end
        end
        CANCEL: begin
          if (data_sram.addr_ok) begin
            state    <= IDLE;
            req_hold <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign es2ms_valid     = (state == DONE);
  assign es2ms_payload   = payload_q;
  assign es_wait_data_ok = wait_q;
  assign es_addr_lo      = addr_q[1:0];
  assign es_ale          = ale_q;
  assign es_drop_data_ok = (orphan_cnt != '0);

  assign data_sram.req   = req_c;
  assign data_sram.wr    = we_q;
  assign data_sram.size  = size_q;
  assign data_sram.wstrb = wstrb_q;
  assign data_sram.addr  = addr_q;
  assign data_sram.wdata = wdata_q;

endmodule

// File: tb/tb_exe_mem_req.sv
// tb_exe_mem_req: directed self-checking bench for exe_mem_req (default and ES_ALE_CHECK_EN builds).
module tb_exe_mem_req;
  localparam int unsigned PW = 150;

  logic          clk;
  logic          resetn;
  logic          ds2es_valid;
  logic          es_allowin;
  logic          ds_mem_en;
  logic          ds_mem_we;
  logic [1:0]    ds_mem_size;
  logic [31:0]   ds_mem_addr;
  logic [31:0]   ds_store_data;
  logic [PW-1:0] ds_payload;
  logic          ms_allowin;
  logic          es2ms_valid;
  logic [PW-1:0] es2ms_payload;
  logic          es_wait_data_ok;
  logic [1:0]    es_addr_lo;
  logic          es_ale;
  logic          es_drop_data_ok;
  logic          ms_ex;
  logic          wb_ex;

  int total;
  int bad;

  logic [PW-1:0] p1, p2, p3, p6;

  exe_mem_req_if sram ();

  exe_mem_req #(.PAYLOAD_W(PW), .ORPHAN_W(2)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .ds2es_valid     (ds2es_valid),
    .es_allowin      (es_allowin),
    .ds_mem_en       (ds_mem_en),
    .ds_mem_we       (ds_mem_we),
    .ds_mem_size     (ds_mem_size),
    .ds_mem_addr     (ds_mem_addr),
    .ds_store_data   (ds_store_data),
    .ds_payload      (ds_payload),
    .ms_allowin      (ms_allowin),
    .es2ms_valid     (es2ms_valid),
    .es2ms_payload   (es2ms_payload),
    .es_wait_data_ok (es_wait_data_ok),
    .es_addr_lo      (es_addr_lo),
    .es_ale          (es_ale),
    .es_drop_data_ok (es_drop_data_ok),
    .data_sram       (sram),
    .ms_ex           (ms_ex),
    .wb_ex           (wb_ex)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chkp(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] data, input logic [PW-1:0] pl);
    ds2es_valid   = 1'b1;
    ds_mem_en     = 1'b1;
    ds_mem_we     = we;
    ds_mem_size   = size;
    ds_mem_addr   = addr;
    ds_store_data = data;
    ds_payload    = pl;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    p1 = '0; p1[149:140] = 10'h2A5; p1[31:0] = 32'h11110001;
    p2 = '0; p2[31:0] = 32'h22220002;
    p3 = '0; p3[149] = 1'b1; p3[31:0] = 32'h33330003;
    p6 = '0; p6[100:69] = 32'hCAFEF00D;

    resetn = 1'b0; ds2es_valid = 1'b0; ds_mem_en = 1'b0; ds_mem_we = 1'b0;
    ds_mem_size = 2'd0; ds_mem_addr = 32'd0; ds_store_data = 32'd0; ds_payload = '0;
    ms_allowin = 1'b0; ms_ex = 1'b0; wb_ex = 1'b0;
    sram.addr_ok = 1'b0; sram.data_ok = 1'b0;
    #12;
    chk("rst_allowin", 32'(es_allowin), 32'd1);
    chk("rst_valid", 32'(es2ms_valid), 32'd0);
    chk("rst_req", 32'(sram.req), 32'd0);
    chk("rst_addr", sram.addr, 32'd0);
    chk("rst_wait_drop", {30'd0, es_wait_data_ok, es_drop_data_ok}, 32'd0);
    chkp("rst_payload", es2ms_payload, '0);
    resetn = 1'b1;
    tick();

    // Load word at 0x1000, addr_ok on third request cycle
    drive(1'b0, 2'd2, 32'h1000, 32'hDEADBEEF, p1);
    tick();
    ds2es_valid = 1'b0;
    settle();
    chk("ldw_req_c1", 32'(sram.req), 32'd1);
    chk("ldw_addr", sram.addr, 32'h1000);
    chk("ldw_wstrb", 32'(sram.wstrb), 32'd0);
    chk("ldw_wr", 32'(sram.wr), 32'd0);
    chk("ldw_allowin_req", 32'(es_allowin), 32'd0);
    tick();
    chk("ldw_req_c2", 32'(sram.req), 32'd1);
    tick();
    sram.addr_ok = 1'b1;
    settle();
    chk("ldw_req_c3", 32'(sram.req), 32'd1);
    tick();
    sram.addr_ok = 1'b0;
    settle();
    chk("ldw_done_valid", 32'(es2ms_valid), 32'd1);
    chk("ldw_done_wait", 32'(es_wait_data_ok), 32'd1);
    chk("ldw_done_req", 32'(sram.req), 32'd0);
    chkp("ldw_payload", es2ms_payload, p1);
    chk("ldw_allowin_stall", 32'(es_allowin), 32'd0);
    ms_allowin = 1'b1;
    settle();
    chk("ldw_allowin_go", 32'(es_allowin), 32'd1);
    tick();
    chk("ldw_idle_valid", 32'(es2ms_valid), 32'd0);

    // Store byte 0xA5 at 0x1003, then back-to-back store half 0x1234 at 0x1002
    drive(1'b1, 2'd0, 32'h1003, 32'h000000A5, p2);
    tick();
    ds2es_valid = 1'b0;
    sram.addr_ok = 1'b1;
    settle();
    chk("sb_wstrb", 32'(sram.wstrb), 32'h8);
    chk("sb_wdata", sram.wdata, 32'hA5A5A5A5);
    chk("sb_size", 32'(sram.size), 32'd0);
    chk("sb_wr", 32'(sram.wr), 32'd1);
    chk("sb_addr_lo", 32'(es_addr_lo), 32'd3);
    drive(1'b1, 2'd1, 32'h1002, 32'h00001234, p3);
    tick();
    sram.addr_ok = 1'b0;
    settle();
    chk("sb_done_valid", 32'(es2ms_valid), 32'd1);
    chk("sb_done_allowin", 32'(es_allowin), 32'd1);
    chkp("sb_payload", es2ms_payload, p2);
    tick();
    ds2es_valid = 1'b0;
    sram.addr_ok = 1'b1;
    settle();
    chk("sh_req", 32'(sram.req), 32'd1);
    chk("sh_wstrb", 32'(sram.wstrb), 32'hC);
    chk("sh_wdata", sram.wdata, 32'h12341234);
    chk("sh_size", 32'(sram.size), 32'd1);
    tick();
    sram.addr_ok = 1'b0;
    settle();
    chkp("sh_payload", es2ms_payload, p3);
    tick();

    // Misaligned half load at 0x1001
    drive(1'b0, 2'd1, 32'h1001, 32'd0, p2);
    tick();
    ds2es_valid = 1'b0;
    settle();
`ifdef ES_ALE_CHECK_EN
    chk("ale_req", 32'(sram.req), 32'd0);
    chk("ale_flag", 32'(es_ale), 32'd1);
    chk("ale_valid", 32'(es2ms_valid), 32'd1);
    chk("ale_wait", 32'(es_wait_data_ok), 32'd0);
    tick();
`else
    chk("mis_req", 32'(sram.req), 32'd1);
    chk("mis_ale", 32'(es_ale), 32'd0);
    chk("mis_addr", sram.addr, 32'h1001);
    chk("mis_wstrb", 32'(sram.wstrb), 32'd0);
    sram.addr_ok = 1'b1;
    tick();
    sram.addr_ok = 1'b0;
    settle();
    chk("mis_valid", 32'(es2ms_valid), 32'd1);
    tick();
`endif

    // Flush while request held -> CANCEL, orphan counted then drained
    drive(1'b0, 2'd2, 32'h2000, 32'd0, p1);
    tick();
    ds2es_valid = 1'b0;
    settle();
    chk("cx_req", 32'(sram.req), 32'd1);
    tick();
    wb_ex = 1'b1;
    settle();
    chk("cx_req_held_wb", 32'(sram.req), 32'd1);
    tick();
    wb_ex = 1'b0;
    settle();
    chk("cx_cancel_valid", 32'(es2ms_valid), 32'd0);
    chk("cx_cancel_req", 32'(sram.req), 32'd1);
    chk("cx_cancel_allowin", 32'(es_allowin), 32'd0);
    tick();
    sram.addr_ok = 1'b1;
    tick();
    sram.addr_ok = 1'b0;
    settle();
    chk("cx_drop", 32'(es_drop_data_ok), 32'd1);
    chk("cx_idle_allowin", 32'(es_allowin), 32'd1);
    chk("cx_idle_req", 32'(sram.req), 32'd0);
    sram.data_ok = 1'b1;
    tick();
    sram.data_ok = 1'b0;
    settle();
    chk("cx_drained", 32'(es_drop_data_ok), 32'd0);

    // ms_ex blocks a new request; once raised, req holds through ms_ex
    ms_ex = 1'b1;
    drive(1'b0, 2'd2, 32'h3000, 32'd0, p6);
    tick();
    ds2es_valid = 1'b0;
    settle();
    chk("msex_req_blk1", 32'(sram.req), 32'd0);
    tick();
    chk("msex_req_blk2", 32'(sram.req), 32'd0);
    ms_ex = 1'b0;
    settle();
    chk("msex_req_go", 32'(sram.req), 32'd1);
    tick();
    ms_ex = 1'b1;
    settle();
    chk("msex_req_hold1", 32'(sram.req), 32'd1);
    tick();
    chk("msex_req_hold2", 32'(sram.req), 32'd1);
    sram.addr_ok = 1'b1;
    ms_allowin = 1'b0;
    tick();
    sram.addr_ok = 1'b0;
    ms_ex = 1'b0;
    settle();
    chk("msex_wait", 32'(es_wait_data_ok), 32'd1);

    // MEM stall: DONE holds payload and blocks upstream for 4 cycles
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", 32'(es2ms_valid), 32'd1);
      chk("stall_allowin", 32'(es_allowin), 32'd0);
      chkp("stall_payload", es2ms_payload, p6);
      tick();
    end
    ms_allowin = 1'b1;
    tick();

    // Flush before any request raised: no request, no orphan
    ms_ex = 1'b1;
    drive(1'b0, 2'd2, 32'h4000, 32'd0, p1);
    tick();
    ds2es_valid = 1'b0;
    ms_ex = 1'b0;
    wb_ex = 1'b1;
    settle();
    chk("wbnh_req", 32'(sram.req), 32'd0);
    tick();
    wb_ex = 1'b0;
    settle();
    chk("wbnh_valid", 32'(es2ms_valid), 32'd0);
    chk("wbnh_drop", 32'(es_drop_data_ok), 32'd0);
    chk("wbnh_allowin", 32'(es_allowin), 32'd1);

    // Flush coincident with addr_ok -> orphan count 1
    drive(1'b0, 2'd2, 32'h5000, 32'd0, p1);
    tick();
    ds2es_valid = 1'b0;
    tick();
    wb_ex = 1'b1;
    sram.addr_ok = 1'b1;
    settle();
    chk("wbok_req", 32'(sram.req), 32'd1);
    tick();
    wb_ex = 1'b0;
    sram.addr_ok = 1'b0;
    settle();
    chk("wbok_valid", 32'(es2ms_valid), 32'd0);
    chk("wbok_drop", 32'(es_drop_data_ok), 32'd1);

    // Flush in DONE after acceptance -> orphan count 2
    ms_allowin = 1'b0;
    drive(1'b0, 2'd2, 32'h6000, 32'd0, p1);
    tick();
    ds2es_valid = 1'b0;
    sram.addr_ok = 1'b1;
    tick();
    sram.addr_ok = 1'b0;
    wb_ex = 1'b1;
    settle();
    chk("wbdone_valid", 32'(es2ms_valid), 32'd1);
    tick();
    wb_ex = 1'b0;
    settle();
    chk("wbdone_idle", 32'(es2ms_valid), 32'd0);
    chk("wbdone_allowin", 32'(es_allowin), 32'd1);

    // Simultaneous inc and dec keeps count at 2
    drive(1'b0, 2'd2, 32'h6100, 32'd0, p1);
    tick();
    ds2es_valid = 1'b0;
    tick();
    wb_ex = 1'b1;
    sram.addr_ok = 1'b1;
    sram.data_ok = 1'b1;
    tick();
    wb_ex = 1'b0;
    sram.addr_ok = 1'b0;
    sram.data_ok = 1'b0;
    settle();
    chk("incdec_allowin", 32'(es_allowin), 32'd1);

    // Reach count 3 (max): upstream blocked
    drive(1'b0, 2'd2, 32'h6200, 32'd0, p1);
    tick();
    ds2es_valid = 1'b0;
    tick();
    wb_ex = 1'b1;
    sram.addr_ok = 1'b1;
    tick();
    wb_ex = 1'b0;
    sram.addr_ok = 1'b0;
    settle();
    chk("max_allowin", 32'(es_allowin), 32'd0);
    chk("max_drop", 32'(es_drop_data_ok), 32'd1);
    drive(1'b0, 2'd2, 32'h7000, 32'd0, p1);
    tick();
    ds2es_valid = 1'b0;
    settle();
    chk("max_no_load_req", 32'(sram.req), 32'd0);
    chk("max_no_load_valid", 32'(es2ms_valid), 32'd0);
    sram.data_ok = 1'b1;
    tick();
    sram.data_ok = 1'b0;
    settle();
    chk("max_dec_allowin", 32'(es_allowin), 32'd1);
    chk("max_dec_drop", 32'(es_drop_data_ok), 32'd1);
    sram.data_ok = 1'b1;
    tick();
    tick();
    tick();
    sram.data_ok = 1'b0;
    settle();
    chk("drain_zero", 32'(es_drop_data_ok), 32'd0);

    // Async reset in the middle of REQ
    drive(1'b0, 2'd2, 32'h8000, 32'd0, p2);
    tick();
    ds2es_valid = 1'b0;
    settle();
    chk("arst_req_before", 32'(sram.req), 32'd1);
    resetn = 1'b0;
    #1;
    chk("arst_req", 32'(sram.req), 32'd0);
    chk("arst_allowin", 32'(es_allowin), 32'd1);
    chk("arst_addr", sram.addr, 32'd0);
    resetn = 1'b1;
    tick();
    chk("arst_post_valid", 32'(es2ms_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
